// File: rtl/dm_cmd_ctrl.sv
// Abstract-command controller for the Debug Module: decodes DMI accesses into CSR strobes,
// buffers responses in a small FIFO and tracks command issue/busy state plus sticky cmderr.
module dm_cmd_ctrl #(
  parameter int unsigned DATA_COUNT   = 2,
  parameter int unsigned PROGBUF_SIZE = 8,
  parameter int unsigned RESP_DEPTH   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dmactive_i,
  input  logic                    dmi_req_valid_i,
  output logic                    dmi_req_ready_o,
  input  logic [6:0]              dmi_req_addr_i,
  input  logic [1:0]              dmi_req_op_i,
  input  logic [31:0]             dmi_req_data_i,
  output logic                    dmi_resp_valid_o,
  input  logic                    dmi_resp_ready_i,
  output logic [31:0]             dmi_resp_data_o,
  output logic [1:0]              dmi_resp_resp_o,
  output logic [7:0]              csr_addr_o,
  output logic                    csr_we_o,
  output logic                    csr_re_o,
  input  logic [31:0]             csr_rdata_i,
  input  logic [DATA_COUNT-1:0]   autoexecdata_i,
  input  logic [PROGBUF_SIZE-1:0] autoexecprogbuf_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  input  logic                    cmd_done_i,
  input  logic [2:0]              cmd_err_i,
  output logic                    cmdbusy_o,
  output logic [2:0]              cmderr_o
);

  localparam int unsigned PtrW = $clog2(RESP_DEPTH);

  localparam logic [6:0] AddrData0    = 7'h04;
  localparam logic [6:0] AddrDmStatus = 7'h11;
  localparam logic [6:0] AddrHartinfo = 7'h12;
  localparam logic [6:0] AddrAbsCs    = 7'h16;
  localparam logic [6:0] AddrCommand  = 7'h17;
  localparam logic [6:0] AddrAbsAuto  = 7'h18;
  localparam logic [6:0] AddrNextDm   = 7'h1d;
  localparam logic [6:0] AddrProgbuf0 = 7'h20;

  typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cmderr_q, cmderr_d;
  logic            cmd_valid_q;
  logic [PtrW:0]   count_q, count_d;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [31:0]     mem_q [RESP_DEPTH];

  logic soft_rst, fifo_full, fifo_empty, accept, pop, is_rd, is_wr;
  logic data_hit, pb_hit, auto_hit, trigger, busy_err, eng_err, w1c;
  logic unused_wdata;

  // Only the cmderr clear bits are consumed here; the CSR file takes write data directly.
  assign unused_wdata = ^{dmi_req_data_i[31:11], dmi_req_data_i[7:0]};

  assign soft_rst   = rst_i | ~dmactive_i;
  assign fifo_full  = (count_q == (PtrW+1)'(RESP_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign dmi_req_ready_o  = ~soft_rst & ~fifo_full;
  assign accept           = dmi_req_valid_i & dmi_req_ready_o;
  assign is_rd            = (dmi_req_op_i == 2'd1);
  assign is_wr            = (dmi_req_op_i == 2'd2);
  assign dmi_resp_valid_o = ~fifo_empty;
  assign pop              = dmi_resp_valid_o & dmi_resp_ready_i;
  assign dmi_resp_data_o  = fifo_empty ? 32'h0 : mem_q[rptr_q];
  assign dmi_resp_resp_o  = 2'b00;

  assign csr_addr_o = {1'b0, dmi_req_addr_i};
  assign csr_re_o   = accept & is_rd;
  assign csr_we_o   = accept & is_wr & (dmi_req_addr_i != AddrDmStatus) &
                      (dmi_req_addr_i != AddrHartinfo) & (dmi_req_addr_i != AddrNextDm);

  always_comb begin
    data_hit = 1'b0;
    pb_hit   = 1'b0;
    auto_hit = 1'b0;
    for (int unsigned i = 0; i < DATA_COUNT; i++) begin
      if (dmi_req_addr_i == 7'(AddrData0 + i)) begin
        data_hit = 1'b1;
        auto_hit = autoexecdata_i[i];
      end
    end
    for (int unsigned i = 0; i < PROGBUF_SIZE; i++) begin
      if (dmi_req_addr_i == 7'(AddrProgbuf0 + i)) begin
        pb_hit   = 1'b1;
        auto_hit = autoexecprogbuf_i[i];
      end
    end
  end

  assign trigger  = (state_q == StIdle) & (cmderr_q == 3'd0) & accept &
                    ((is_wr & (dmi_req_addr_i == AddrCommand)) | ((is_rd | is_wr) & auto_hit));
  assign busy_err = cmdbusy_o & accept &
                    ((is_wr & ((dmi_req_addr_i == AddrCommand) | (dmi_req_addr_i == AddrAbsCs) |
                               (dmi_req_addr_i == AddrAbsAuto))) |
                     ((is_rd | is_wr) & (data_hit | pb_hit)));
  assign eng_err  = (state_q == StBusy) & cmd_done_i & (cmd_err_i != 3'd0) & (cmderr_q == 3'd0);
  assign w1c      = (state_q == StIdle) & accept & is_wr & (dmi_req_addr_i == AddrAbsCs);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (trigger)     state_d = StIssue;
      StIssue: if (cmd_ready_i) state_d = StBusy;
      StBusy:  if (cmd_done_i)  state_d = StIdle;
      default:                  state_d = StIdle;
    endcase
  end

  // Engine error outranks busy error, which outranks the write-1-to-clear.
  always_comb begin
    cmderr_d = cmderr_q;
    if (eng_err) begin
      cmderr_d = cmd_err_i;
    end else if (busy_err) begin
      if (cmderr_q == 3'd0) cmderr_d = 3'd1;
    end else if (w1c) begin
      cmderr_d = cmderr_q & ~dmi_req_data_i[10:8];
    end
  end

  always_comb begin
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + (PtrW+1)'(1);
    else if (!accept && pop) count_d = count_q - (PtrW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q     <= StIdle;
      cmderr_q    <= 3'd0;
      cmd_valid_q <= 1'b0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmderr_q    <= cmderr_d;
      cmd_valid_q <= (state_d == StIssue);
      count_q     <= count_d;
      if (accept) begin
        mem_q[wptr_q] <= is_rd ? csr_rdata_i : 32'h0;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmdbusy_o   = (state_q != StIdle);
  assign cmderr_o    = cmderr_q;

endmodule

// File: tb/tb_dm_cmd_ctrl.sv
// Randomized and directed bench for dm_cmd_ctrl: a behavioural model predicts handshakes and
// cmderr/busy, a scoreboard queue carries expected responses to an independent monitor.
module tb_dm_cmd_ctrl;
  localparam int DC    = 2;
  localparam int PB    = 8;
  localparam int DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, dmactive_i;
  logic          dmi_req_valid_i, dmi_req_ready_o;
  logic [6:0]    dmi_req_addr_i;
  logic [1:0]    dmi_req_op_i;
  logic [31:0]   dmi_req_data_i;
  logic          dmi_resp_valid_o, dmi_resp_ready_i;
  logic [31:0]   dmi_resp_data_o;
  logic [1:0]    dmi_resp_resp_o;
  logic [7:0]    csr_addr_o;
  logic          csr_we_o, csr_re_o;
  logic [31:0]   csr_rdata_i;
  logic [DC-1:0] autoexecdata_i;
  logic [PB-1:0] autoexecprogbuf_i;
  logic          cmd_valid_o, cmd_ready_i, cmd_done_i;
  logic [2:0]    cmd_err_i;
  logic          cmdbusy_o;
  logic [2:0]    cmderr_o;

  always #5 clk_i = ~clk_i;

  dm_cmd_ctrl #(.DATA_COUNT(DC), .PROGBUF_SIZE(PB), .RESP_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dmactive_i(dmactive_i),
    .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_req_addr_i(dmi_req_addr_i), .dmi_req_op_i(dmi_req_op_i),
    .dmi_req_data_i(dmi_req_data_i),
    .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
    .dmi_resp_data_o(dmi_resp_data_o), .dmi_resp_resp_o(dmi_resp_resp_o),
    .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_re_o(csr_re_o),
    .csr_rdata_i(csr_rdata_i),
    .autoexecdata_i(autoexecdata_i), .autoexecprogbuf_i(autoexecprogbuf_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_done_i(cmd_done_i),
    .cmd_err_i(cmd_err_i), .cmdbusy_o(cmdbusy_o), .cmderr_o(cmderr_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard of expected response data; its length is also the expected FIFO occupancy.
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;

  // Reference model state: a command requested but not yet taken, or taken and running.
  bit          m_pending = 1'b0;
  bit          m_running = 1'b0;
  logic [2:0]  m_err = 3'd0;
  bit          push_pend = 1'b0;
  bit          flush = 1'b0;
  logic [31:0] push_val = 32'h0;

  always @(negedge clk_i) begin
    if (mon_en) begin
      bit ready_e, acc, rd, wr, busy, is_data, is_pb, auto;
      int a;
      logic [2:0] old_err;
      ready_e = !rst_i && dmactive_i && (exp_q.size() < DEPTH);
      check("req_ready", dmi_req_ready_o, ready_e);
      check("cmd_valid", cmd_valid_o, m_pending);
      check("cmdbusy", cmdbusy_o, m_pending || m_running);
      check("cmderr", cmderr_o, m_err);
      acc = dmi_req_valid_i && ready_e;
      rd  = acc && (dmi_req_op_i == 2'd1);
      wr  = acc && (dmi_req_op_i == 2'd2);
      a   = int'(dmi_req_addr_i);
      is_data = (a >= 4) && (a < 4 + DC);
      is_pb   = (a >= 32) && (a < 32 + PB);
      auto = 1'b0;
      if (is_data) auto = autoexecdata_i[a-4];
      if (is_pb)   auto = autoexecprogbuf_i[a-32];
      check("csr_re", csr_re_o, rd);
      check("csr_we", csr_we_o, wr && !(a inside {'h11, 'h12, 'h1d}));
      if (acc) check("csr_addr", csr_addr_o, {1'b0, dmi_req_addr_i});
      push_pend = acc;
      push_val  = rd ? csr_rdata_i : 32'h0;
      flush     = rst_i || !dmactive_i;
      if (flush) begin
        m_pending = 1'b0;
        m_running = 1'b0;
        m_err     = 3'd0;
      end else begin
        busy    = m_pending || m_running;
        old_err = m_err;
        if (m_running && cmd_done_i && cmd_err_i != 3'd0 && old_err == 3'd0) begin
          m_err = cmd_err_i;
        end else if (busy && ((wr && a inside {'h16, 'h17, 'h18}) ||
                              ((rd || wr) && (is_data || is_pb)))) begin
          if (old_err == 3'd0) m_err = 3'd1;
        end else if (!busy && wr && a == 'h16) begin
          m_err = old_err & ~dmi_req_data_i[10:8];
        end
        if (!busy && old_err == 3'd0 && ((wr && a == 'h17) || ((rd || wr) && auto))) begin
          m_pending = 1'b1;
        end else if (m_pending && cmd_ready_i) begin
          m_pending = 1'b0;
          m_running = 1'b1;
        end else if (m_running && cmd_done_i) begin
          m_running = 1'b0;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (mon_en) begin
      if (flush) exp_q.delete();
      else if (push_pend) exp_q.push_back(push_val);
    end
  end

  // Monitor: runs just after the model has sampled occupancy, pops on each response handshake.
  always @(negedge clk_i) begin
    if (mon_en) begin
      logic [31:0] e;
      #1;
      check("resp_valid", dmi_resp_valid_o, exp_q.size() != 0);
      if (dmi_resp_valid_o && dmi_resp_ready_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_data", dmi_resp_data_o, e);
        check("resp_code", dmi_resp_resp_o, 2'b00);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Hold a request until the DUT takes it; bounded so a stuck ready cannot hang the run.
  task automatic req(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd);
    bit acc;
    int n;
    dmi_req_valid_i = 1'b1;
    dmi_req_op_i    = op;
    dmi_req_addr_i  = addr;
    dmi_req_data_i  = wd;
    csr_rdata_i     = rd;
    n = 0;
    do begin
      @(negedge clk_i);
      acc = dmi_req_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!acc && n < 20);
    dmi_req_valid_i = 1'b0;
    if (!acc) check("req_accept_timeout", acc, 1'b1);
  endtask

  task automatic engine_take_and_finish(input logic [2:0] err);
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    tick();
    cmd_done_i = 1'b1;
    cmd_err_i  = err;
    tick();
    cmd_done_i = 1'b0;
    cmd_err_i  = 3'd0;
    tick();
  endtask

  logic [6:0] addrs [14] = '{7'h04, 7'h05, 7'h06, 7'h11, 7'h12, 7'h16, 7'h17, 7'h18, 7'h1d,
                             7'h20, 7'h27, 7'h28, 7'h10, 7'h00};

  initial begin
    rst_i = 1'b1; dmactive_i = 1'b1;
    dmi_req_valid_i = 1'b0; dmi_req_addr_i = '0; dmi_req_op_i = '0; dmi_req_data_i = '0;
    dmi_resp_ready_i = 1'b0; csr_rdata_i = '0;
    autoexecdata_i = '0; autoexecprogbuf_i = '0;
    cmd_ready_i = 1'b0; cmd_done_i = 1'b0; cmd_err_i = '0;
    tick();
    mon_en = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();

    // FIFO fills at two entries; third read waits until a response drains.
    req(2'd1, 7'h04, 32'h0, 32'h11);
    req(2'd1, 7'h04, 32'h0, 32'h22);
    fork
      req(2'd1, 7'h04, 32'h0, 32'h33);
      begin
        repeat (3) tick();
        dmi_resp_ready_i = 1'b1;
      end
    join
    repeat (3) tick();

    // Command while idle: valid held three cycles, then a clean completion.
    req(2'd2, 7'h17, 32'h0, 32'h0);
    repeat (2) tick();
    engine_take_and_finish(3'd0);

    // Command while busy: busy error, engine error masked, then cleared by W1C.
    req(2'd2, 7'h17, 32'h0, 32'h0);
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    req(2'd2, 7'h17, 32'h0, 32'h0);
    tick();
    cmd_done_i = 1'b1; cmd_err_i = 3'd3;
    tick();
    cmd_done_i = 1'b0; cmd_err_i = 3'd0;
    req(2'd2, 7'h16, 32'h0000_0100, 32'h0);
    tick();

    // Autoexec on data1 only; suppressed once cmderr is nonzero.
    autoexecdata_i = 2'b10;
    req(2'd2, 7'h05, 32'hA5A5_0001, 32'h0);
    engine_take_and_finish(3'd0);
    req(2'd2, 7'h04, 32'hA5A5_0002, 32'h0);
    tick();
    req(2'd2, 7'h17, 32'h0, 32'h0);
    engine_take_and_finish(3'd2);
    req(2'd2, 7'h05, 32'hA5A5_0003, 32'h0);
    repeat (2) tick();
    req(2'd2, 7'h16, 32'h0000_0700, 32'h0);
    autoexecdata_i = 2'b00;

    // Read-only registers drop the write but still answer.
    req(2'd2, 7'h11, 32'hFFFF_FFFF, 32'h0);
    req(2'd2, 7'h12, 32'hFFFF_FFFF, 32'h0);
    req(2'd2, 7'h1d, 32'hFFFF_FFFF, 32'h0);
    repeat (2) tick();

    // Deactivate while busy with two queued responses; late done must be ignored.
    req(2'd2, 7'h17, 32'h0, 32'h0);
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    dmi_resp_ready_i = 1'b0;
    req(2'd1, 7'h06, 32'h0, 32'hDEAD_0001);
    req(2'd1, 7'h07, 32'h0, 32'hDEAD_0002);
    dmactive_i = 1'b0;
    tick();
    dmactive_i = 1'b1;
    tick();
    cmd_done_i = 1'b1; cmd_err_i = 3'd5;
    tick();
    cmd_done_i = 1'b0; cmd_err_i = 3'd0;
    dmi_resp_ready_i = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 3000; i++) begin
      int idx;
      idx = $urandom_range(0, 13);
      dmi_req_valid_i  = ($urandom_range(0, 2) != 0);
      dmi_req_addr_i   = (idx == 13) ? 7'($urandom) : addrs[idx];
      dmi_req_op_i     = 2'($urandom_range(0, 3));
      dmi_req_data_i   = $urandom;
      csr_rdata_i      = $urandom;
      dmi_resp_ready_i = ($urandom_range(0, 3) != 0);
      cmd_ready_i      = ($urandom_range(0, 2) == 0);
      cmd_done_i       = ($urandom_range(0, 5) == 0);
      cmd_err_i        = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      dmactive_i       = ($urandom_range(0, 63) != 0);
      rst_i            = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 31) == 0) begin
        autoexecdata_i    = DC'($urandom);
        autoexecprogbuf_i = PB'($urandom);
      end
      tick();
    end

    dmi_req_valid_i = 1'b0; cmd_done_i = 1'b0; rst_i = 1'b0; dmactive_i = 1'b1;
    dmi_resp_ready_i = 1'b1;
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
